// File: rtl/tqvp_ps2_pkg.sv
// rtl/tqvp_ps2_pkg.sv - register map, bit indices and FSM encoding for the PS/2 console receiver
package tqvp_ps2_pkg;

    localparam logic [5:0] ADDR_DATA   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h04;
    localparam logic [5:0] ADDR_CTRL   = 6'h08;

    localparam int DATA_BIT_VALID   = 8;
    localparam int ST_BIT_EMPTY     = 0;
    localparam int ST_BIT_FULL      = 1;
    localparam int ST_BIT_OVERFLOW  = 2;
    localparam int ST_BIT_PARITY    = 3;
    localparam int ST_BIT_FRAME     = 4;
    localparam int ST_COUNT_LSB     = 8;

    localparam int CTRL_RX_EN       = 0;
    localparam int CTRL_IRQ_EN      = 1;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = FRAME_BITS - 3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - synchronous scancode FIFO with head-of-queue read
module ps2_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    wire do_pop  = pop && !empty;
    wire do_push = push && (!full || do_pop);

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tqvp_ps2_console_rx.sv
// rtl/tqvp_ps2_console_rx.sv - TinyQV PS/2 keyboard receiver peripheral
// Optional mid-frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module tqvp_ps2_console_rx
    import tqvp_ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int BW = $clog2(DATA_BITS);

    wire ps2_clk_raw = ui_in[1];
    wire ps2_data    = ui_in[2];

    logic [1:0] ctrl;
    logic       ovf_flag;
    logic       par_flag;
    logic       frm_flag;

    // ---------------- clock glitch filter and falling-edge strobe ----------------
    logic          filt_clk;
    logic [FW-1:0] flt_cnt;

    wire flt_flip = (ps2_clk_raw != filt_clk) && (flt_cnt == FW'(FILTER_LEN - 1));
    wire strobe   = flt_flip && filt_clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk <= 1'b1;
            flt_cnt  <= '0;
        end else if (ps2_clk_raw == filt_clk) begin
            flt_cnt <= '0;
        end else if (flt_flip) begin
            filt_clk <= ps2_clk_raw;
            flt_cnt  <= '0;
        end else begin
            flt_cnt <= flt_cnt + FW'(1);
        end
    end

    // ---------------- frame FSM ----------------
    rx_state_t            rx_state;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 push_q;
    logic                 par_err_q;
    logic                 frm_err_q;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt;
    wire wd_expired = (rx_state != RX_IDLE) && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    wire wd_expired = 1'b0;
    wire unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RX_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            push_q    <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
        end else begin
            push_q    <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            if (!ctrl[CTRL_RX_EN]) begin
                rx_state <= RX_IDLE;
            end else if (strobe) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (!ps2_data) begin
                            rx_state <= RX_DATA;
                            bit_cnt  <= '0;
                        end
                    end
                    RX_DATA: begin
                        shreg   <= {ps2_data, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            rx_state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        par_bit  <= ps2_data;
                        rx_state <= RX_STOP;
                    end
                    default: begin
                        if (!ps2_data) begin
                            frm_err_q <= 1'b1;
                        end else if (!odd_parity_ok(shreg, par_bit)) begin
                            par_err_q <= 1'b1;
                        end else begin
                            push_q <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end
                endcase
            end else if (wd_expired) begin
                rx_state  <= RX_IDLE;
                frm_err_q <= 1'b1;
            end
`ifdef PS2_RX_TIMEOUT_EN
            if (!ctrl[CTRL_RX_EN] || strobe || rx_state == RX_IDLE) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + TW'(1);
            end
`endif
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    wire rd_en     = (data_read_n != 2'b11);
    wire wr_en     = (data_write_n != 2'b11);
    wire fifo_pop  = rd_en && (address == ADDR_DATA) && !fifo_empty;
    wire wr_status = wr_en && (address == ADDR_STATUS);
    wire wr_ctrl   = wr_en && (address == ADDR_CTRL);
    wire ovf_set   = push_q && fifo_full && !fifo_pop;

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .wdata (shreg),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // ---------------- registers ----------------
    // A flag raised in the same cycle as its clear stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= 2'b01;
            ovf_flag <= 1'b0;
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= data_in[1:0];
            end
            ovf_flag <= ovf_set   | (ovf_flag & ~(wr_status & data_in[ST_BIT_OVERFLOW]));
            par_flag <= par_err_q | (par_flag & ~(wr_status & data_in[ST_BIT_PARITY]));
            frm_flag <= frm_err_q | (frm_flag & ~(wr_status & data_in[ST_BIT_FRAME]));
        end
    end

    logic [31:0] count_ext;
    assign count_ext = 32'(fifo_count);

    always_comb begin
        data_out = 32'h0;
        case (address)
            ADDR_DATA: begin
                data_out[DATA_BIT_VALID] = !fifo_empty;
                data_out[7:0]            = fifo_empty ? 8'h00 : fifo_head;
            end
            ADDR_STATUS: begin
                data_out[ST_BIT_EMPTY]         = fifo_empty;
                data_out[ST_BIT_FULL]          = fifo_full;
                data_out[ST_BIT_OVERFLOW]      = ovf_flag;
                data_out[ST_BIT_PARITY]        = par_flag;
                data_out[ST_BIT_FRAME]         = frm_flag;
                data_out[ST_COUNT_LSB +: 4]    = count_ext[3:0];
            end
            ADDR_CTRL: begin
                data_out[1:0] = ctrl;
            end
            default: data_out = 32'h0;
        endcase
    end

    assign uo_out         = 8'h00;
    assign data_ready     = 1'b1;
    assign user_interrupt = ctrl[CTRL_IRQ_EN] & !fifo_empty;

    wire unused_inputs = &{1'b0, ui_in[7:3], ui_in[0], data_in[31:5], count_ext[31:4]};

endmodule

// File: tb/tb_tqvp_ps2_console_rx.sv
// tb/tb_tqvp_ps2_console_rx.sv - directed self-checking bench for the PS/2 console receiver
module tb_tqvp_ps2_console_rx;

    localparam int HP      = 30;
    localparam int TIMEOUT = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address = 6'h3F;
    logic [31:0] data_in = 32'h0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int errors = 0;
    int checks = 0;

    assign ui_in = {5'b0, ps2_data, ps2_clk, 1'b0};

    always #5 clk = ~clk;

    tqvp_ps2_console_rx #(
        .FIFO_DEPTH     (4),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    task automatic reg_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        address     = a;
        data_read_n = 2'b00;
        #1 d = data_out;
        @(posedge clk);
        #1 data_read_n = 2'b11;
    endtask

    task automatic reg_write(input logic [5:0] a, input logic [31:0] v);
        @(negedge clk);
        address      = a;
        data_in      = v;
        data_write_n = 2'b00;
        @(posedge clk);
        #1 data_write_n = 2'b11;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
        logic p;
        p = ~(^b) ^ flip;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(stop);
        ps2_data = 1'b1;
        repeat (HP) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        #1;
        checks++; if (uo_out !== 8'h00) begin $display("FAIL reset_uo_out got=%h exp=00", uo_out); errors++; end
        checks++; if (user_interrupt !== 1'b0) begin $display("FAIL reset_irq got=%b exp=0", user_interrupt); errors++; end
        checks++; if (data_ready !== 1'b1) begin $display("FAIL reset_data_ready got=%b exp=1", data_ready); errors++; end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        reg_read(6'h04, d);
        checks++; if (d !== 32'h001) begin $display("FAIL reset_status got=%h exp=%h", d, 32'h001); errors++; end
        reg_read(6'h08, d);
        checks++; if (d !== 32'h001) begin $display("FAIL reset_ctrl got=%h exp=%h", d, 32'h001); errors++; end
        reg_read(6'h00, d);
        checks++; if (d !== 32'h000) begin $display("FAIL reset_data got=%h exp=%h", d, 32'h000); errors++; end
        reg_read(6'h10, d);
        checks++; if (d !== 32'h000) begin $display("FAIL unmapped_read got=%h exp=%h", d, 32'h000); errors++; end
    endtask

    task automatic test_good_frame;
        logic [31:0] d;
        reg_write(6'h08, 32'h3);
        send_frame(8'h1C, 1'b0, 1'b1);
        #1;
        checks++; if (user_interrupt !== 1'b1) begin $display("FAIL good_irq_high got=%b exp=1", user_interrupt); errors++; end
        reg_read(6'h00, d);
        checks++; if (d !== 32'h11C) begin $display("FAIL good_data got=%h exp=%h", d, 32'h11C); errors++; end
        @(negedge clk); #1;
        checks++; if (user_interrupt !== 1'b0) begin $display("FAIL good_irq_low got=%b exp=0", user_interrupt); errors++; end
        reg_read(6'h00, d);
        checks++; if (d !== 32'h000) begin $display("FAIL good_empty_read got=%h exp=%h", d, 32'h000); errors++; end
    endtask

    task automatic test_parity_err;
        logic [31:0] d;
        send_frame(8'h1C, 1'b1, 1'b1);
        reg_read(6'h04, d);
        checks++; if (d !== 32'h009) begin $display("FAIL parity_status got=%h exp=%h", d, 32'h009); errors++; end
        reg_write(6'h04, 32'h08);
        reg_read(6'h04, d);
        checks++; if (d !== 32'h001) begin $display("FAIL parity_clear got=%h exp=%h", d, 32'h001); errors++; end
    endtask

    task automatic test_frame_err;
        logic [31:0] d;
        send_frame(8'h3C, 1'b0, 1'b0);
        reg_read(6'h04, d);
        checks++; if (d !== 32'h011) begin $display("FAIL frame_status got=%h exp=%h", d, 32'h011); errors++; end
        reg_write(6'h04, 32'h10);
        reg_read(6'h04, d);
        checks++; if (d !== 32'h001) begin $display("FAIL frame_clear got=%h exp=%h", d, 32'h001); errors++; end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
        reg_read(6'h04, d);
        checks++; if (d !== 32'h406) begin $display("FAIL ovf_status got=%h exp=%h", d, 32'h406); errors++; end
        for (int i = 1; i <= 4; i++) begin
            reg_read(6'h00, d);
            checks++; if (d !== (32'h100 | 32'(i))) begin $display("FAIL ovf_read%0d got=%h exp=%h", i, d, 32'h100 | 32'(i)); errors++; end
        end
        reg_read(6'h04, d);
        checks++; if (d !== 32'h005) begin $display("FAIL ovf_drained got=%h exp=%h", d, 32'h005); errors++; end
        reg_write(6'h04, 32'h04);
        reg_read(6'h04, d);
        checks++; if (d !== 32'h001) begin $display("FAIL ovf_clear got=%h exp=%h", d, 32'h001); errors++; end
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        @(negedge clk);
        ps2_data = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'hA5, 1'b0, 1'b1);
        reg_read(6'h00, d);
        checks++; if (d !== 32'h1A5) begin $display("FAIL glitch_data got=%h exp=%h", d, 32'h1A5); errors++; end
        reg_read(6'h04, d);
        checks++; if (d !== 32'h001) begin $display("FAIL glitch_status got=%h exp=%h", d, 32'h001); errors++; end
    endtask

    task automatic test_rx_disable;
        logic [31:0] d;
        send_frame(8'h33, 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        reg_write(6'h08, 32'h2);
        reg_write(6'h08, 32'h3);
        send_frame(8'h5A, 1'b0, 1'b1);
        reg_read(6'h00, d);
        checks++; if (d !== 32'h133) begin $display("FAIL disable_kept got=%h exp=%h", d, 32'h133); errors++; end
        reg_read(6'h00, d);
        checks++; if (d !== 32'h15A) begin $display("FAIL disable_next got=%h exp=%h", d, 32'h15A); errors++; end
        reg_read(6'h04, d);
        checks++; if (d !== 32'h001) begin $display("FAIL disable_status got=%h exp=%h", d, 32'h001); errors++; end
    endtask

`ifdef PS2_RX_TIMEOUT_EN
    task automatic test_timeout;
        logic [31:0] d;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 200) @(negedge clk);
        reg_read(6'h04, d);
        checks++; if (d !== 32'h011) begin $display("FAIL timeout_status got=%h exp=%h", d, 32'h011); errors++; end
        reg_write(6'h04, 32'h10);
        send_frame(8'h5A, 1'b0, 1'b1);
        reg_read(6'h00, d);
        checks++; if (d !== 32'h15A) begin $display("FAIL timeout_next got=%h exp=%h", d, 32'h15A); errors++; end
    endtask
`endif

    task automatic test_reset_midframe;
        logic [31:0] d;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        reg_read(6'h04, d);
        checks++; if (d !== 32'h200) begin $display("FAIL pre_reset_status got=%h exp=%h", d, 32'h200); errors++; end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        @(negedge clk);
        address = 6'h04;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (user_interrupt !== 1'b0) begin $display("FAIL midreset_irq got=%b exp=0", user_interrupt); errors++; end
        checks++; if (data_out !== 32'h001) begin $display("FAIL midreset_status got=%h exp=%h", data_out, 32'h001); errors++; end
        checks++; if (uo_out !== 8'h00) begin $display("FAIL midreset_uo_out got=%h exp=00", uo_out); errors++; end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        reg_read(6'h08, d);
        checks++; if (d !== 32'h001) begin $display("FAIL midreset_ctrl got=%h exp=%h", d, 32'h001); errors++; end
        send_frame(8'h77, 1'b0, 1'b1);
        reg_read(6'h00, d);
        checks++; if (d !== 32'h177) begin $display("FAIL midreset_next got=%h exp=%h", d, 32'h177); errors++; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        test_good_frame;
        test_parity_err;
        test_frame_err;
        test_overflow;
        test_glitch;
        test_rx_disable;
`ifdef PS2_RX_TIMEOUT_EN
        test_timeout;
`endif
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
